// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: issues word addresses, captures the one-cycle-late
// read data into a 2-entry FIFO and presents it to decode over valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_beat_t;

  logic [31:0] r_pc_issue;
  logic        r_inflight_valid;
  logic [31:0] r_inflight_pc;
  fetch_beat_t r_fifo [2];
  logic [1:0]  r_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic [31:0] w_redirect_pc;

  assign w_pop         = out_valid & out_ready;
  assign w_push        = r_inflight_valid;
  // Occupancy after this edge if nothing new is issued; one free slot is needed
  // for the word that an issue now would push one edge later.
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight_valid} - {2'b00, w_pop};
  assign w_issue       = fetch_en & ~redirect_valid & (w_occ <= 3'd1);
  assign w_redirect_pc = redirect_pc & ~32'h3;

  assign mem_addr  = r_pc_issue;
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_fifo[r_rd_ptr].instr;
  assign out_pc    = r_fifo[r_rd_ptr].pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_issue       <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
      r_fifo[0]        <= '0;
      r_fifo[1]        <= '0;
      r_count          <= '0;
      r_wr_ptr         <= 1'b0;
      r_rd_ptr         <= 1'b0;
    end else if (redirect_valid) begin
      r_pc_issue       <= w_redirect_pc;
      r_inflight_valid <= 1'b0;
      r_count          <= '0;
      r_wr_ptr         <= 1'b0;
      r_rd_ptr         <= 1'b0;
    end else begin
      if (w_issue) begin
        r_inflight_valid <= 1'b1;
        r_inflight_pc    <= r_pc_issue;
        r_pc_issue       <= r_pc_issue + 32'd4;
      end else begin
        r_inflight_valid <= 1'b0;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{pc: r_inflight_pc, instr: mem_data};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid)
      assert (!(w_push && !w_pop && r_count == 2'd2));
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit against a one-cycle-latency memory model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;
  beat_t sb[$];

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // word k: k=0 -> A00000AA, k=1..15 -> k00000kk, above -> C0DE_kkkk
  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [29:0] k;
    logic [3:0]  d;
    k = a[31:2];
    if (k < 30'd16) begin
      d = (k == 30'd0) ? 4'hA : k[3:0];
      return {d, 20'h0, d, d};
    end
    return {16'hC0DE, k[15:0]};
  endfunction

  always @(posedge clk) mem_data <= memw(mem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back('{pc: pc0 + 32'(4 * i), instr: memw(pc0 + 32'(4 * i))});
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    sb.delete();
    step(); step();
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %h want 00000000", out_pc); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h want 00000000", out_instr); end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_latency: out_valid=%b after 1 edge, want 0", out_valid); end
    step();
  endtask

  task automatic test_stream();
    beat_t got;
    int budget = 40;
    push_seq(32'h0, 10);
    while (sb.size() > 0 && budget > 0) begin
      n_cmp++;
      got = {out_pc, out_instr};
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_gap: out_valid=%b want 1 (pc %h)", out_valid, sb[0].pc); end
      else begin
        if (got !== sb[0]) begin n_err++; $display("FAIL stream_beat: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
      end
      step(); budget--;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stream_timeout: %0d beats left, want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    beat_t got;
    int budget = 40;
    do_reset();
    step(); step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin n_err++; $display("FAIL bp_prefix: valid=%b pc=%h want 1/%h", out_valid, out_pc, 32'(4 * i)); end
      step();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      got = {out_pc, out_instr};
      if (out_valid !== 1'b1 || got !== {32'h8, 32'h20000022}) begin
        n_err++; $display("FAIL bp_stable: valid=%b beat=%h want 1/%h", out_valid, got, {32'h8, 32'h20000022});
      end
      step();
    end
    n_cmp++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL bp_mem_addr: got %h want 00000010", mem_addr); end
    n_cmp++; if (dut.r_count !== 2'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", dut.r_count); end
    out_ready = 1'b1;
    push_seq(32'h8, 8);
    while (sb.size() > 0 && budget > 0) begin
      n_cmp++;
      got = {out_pc, out_instr};
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_gap: out_valid=%b want 1 (pc %h)", out_valid, sb[0].pc); end
      else begin
        if (got !== sb[0]) begin n_err++; $display("FAIL bp_beat: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
      end
      step(); budget--;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_timeout: %0d beats left, want 0", sb.size()); end
  endtask

  task automatic test_redirect();
    beat_t got;
    int budget = 20;
    do_reset();
    step(); step(); step(); step();
    n_cmp++; if (out_pc !== 32'h8) begin n_err++; $display("FAIL redir_pre: pc=%h want 00000008", out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h1E;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble0: out_valid=%b want 0", out_valid); end
    n_cmp++; if (mem_addr !== 32'h1C) begin n_err++; $display("FAIL redir_mem_addr: got %h want 0000001c", mem_addr); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble1: out_valid=%b want 0", out_valid); end
    step();
    push_seq(32'h1C, 2);
    while (sb.size() > 0 && budget > 0) begin
      n_cmp++;
      got = {out_pc, out_instr};
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL redir_gap: out_valid=%b want 1 (pc %h)", out_valid, sb[0].pc); end
      else begin
        if (got !== sb[0]) begin n_err++; $display("FAIL redir_beat: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
      end
      step(); budget--;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL redir_timeout: %0d beats left, want 0", sb.size()); end
  endtask

  task automatic test_redirect_full();
    beat_t got;
    int budget = 20;
    do_reset();
    out_ready = 1'b0;
    repeat (4) step();
    n_cmp++; if (dut.r_count !== 2'd2 || out_pc !== 32'h0) begin n_err++; $display("FAIL rfull_pre: count=%0d pc=%h want 2/00000000", dut.r_count, out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rfull_flush0: out_valid=%b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rfull_flush1: out_valid=%b want 0", out_valid); end
    step();
    out_ready = 1'b1;
    push_seq(32'h40, 3);
    while (sb.size() > 0 && budget > 0) begin
      n_cmp++;
      got = {out_pc, out_instr};
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL rfull_gap: out_valid=%b want 1 (pc %h)", out_valid, sb[0].pc); end
      else begin
        if (got !== sb[0]) begin n_err++; $display("FAIL rfull_beat: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
      end
      step(); budget--;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rfull_timeout: %0d beats left, want 0", sb.size()); end
  endtask

  task automatic test_fetch_en_random();
    beat_t got, prev_beat;
    logic prev_hold = 1'b0;
    logic prev_fen = 1'b1;
    logic [31:0] prev_addr = '0;
    int c = 0;
    do_reset();
    push_seq(32'h0, 40);
    while (sb.size() > 0 && c < 600) begin
      got = {out_pc, out_instr};
      if (prev_hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== prev_beat) begin n_err++; $display("FAIL fen_hold: valid=%b beat=%h want 1/%h", out_valid, got, prev_beat); end
      end
      if (!prev_fen) begin
        n_cmp++;
        if (mem_addr !== prev_addr) begin n_err++; $display("FAIL fen_addr_hold: got %h want %h", mem_addr, prev_addr); end
      end
      fetch_en  = ((c / 15) % 2) == 0;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (got !== sb[0]) begin n_err++; $display("FAIL fen_beat: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
      end
      prev_hold = (out_valid === 1'b1) && !out_ready;
      prev_beat = got;
      prev_fen  = fetch_en;
      prev_addr = mem_addr;
      step(); c++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL fen_timeout: %0d beats left, want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    beat_t got;
    int budget = 20;
    do_reset();
    step(); step(); step();
    @(posedge clk); #3;
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL arst_mem_addr: got %h want 00000000", mem_addr); end
    n_cmp++; if ({out_pc, out_instr} !== 64'h0) begin n_err++; $display("FAIL arst_out: got %h want 0", {out_pc, out_instr}); end
    step(); step();
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL arst_vs_redirect: mem_addr %h want 00000000", mem_addr); end
    redirect_valid = 1'b0; rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_latency: out_valid=%b want 0", out_valid); end
    step();
    push_seq(32'h0, 3);
    while (sb.size() > 0 && budget > 0) begin
      n_cmp++;
      got = {out_pc, out_instr};
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_gap: out_valid=%b want 1 (pc %h)", out_valid, sb[0].pc); end
      else begin
        if (got !== sb[0]) begin n_err++; $display("FAIL arst_beat: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
      end
      step(); budget--;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL arst_timeout: %0d beats left, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_fetch_en_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Requester side of the instruction memory port: keeps the program counter and drives a word address onto the memory. It captures the registered read data one cycle later and hands instructions to decode over a valid/ready interface. A 2-entry response FIFO absorbs the memory's fixed one-cycle read latency, so downstream back-pressure never loses an in-flight word. A redirect input (branch/jump) flushes everything in flight and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- fetch_en  input  1  when low, no new addresses are issued; in-flight words still drain
- redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0)
- mem_addr  output  32  byte address to instruction memory; driven directly from the pc_issue register
- mem_data  input  32  memory read data, valid one cycle after mem_addr is sampled (memory indexes addr[31:2])
- out_valid  output  1  out_instr/out_pc hold a fetched instruction
- out_ready  input  1  decode accepts the beat this cycle
- out_instr  output  32  instruction word
- out_pc  output  32  byte address of out_instr

## Operation
- State registers:
  - pc_issue (32)
  - inflight_valid, inflight_pc (32)
  - 2-entry FIFO of {pc, instr} with 2-bit count and rd/wr pointers
- mem_addr = pc_issue at all times. The memory samples it every edge.
- pop = out_valid & out_ready.
- issue = fetch_en & !redirect_valid & ((count + inflight_valid - pop) <= 1).
- At each edge, when redirect_valid = 0:
  - if issue: inflight_valid<=1, inflight_pc<=pc_issue, pc_issue<=pc_issue+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0x0000_0000)
  - else: inflight_valid<=0 and pc_issue holds
  - if inflight_valid: push {inflight_pc, mem_data} into the FIFO
  - if pop: advance the read pointer
  - push and pop in the same cycle are both honoured; count is unchanged
- The FIFO can never overflow by construction. An overflow is an assertion failure in verification.
- Outputs: out_valid = (count != 0); out_instr/out_pc come from the FIFO head entry (registered storage, no combinational path from mem_data).
- Redirect at an edge takes priority over everything else:
  - count<=0, pointers<=0, inflight_valid<=0
  - pc_issue<={redirect_pc[31:2],2'b00}
  - no push that edge; an in-flight word is discarded
  - a beat presented with out_ready=1 in the redirect cycle is still considered consumed by decode
- fetch_en low: pc_issue holds, and the FIFO drains normally. When fetch_en rises, fetch resumes at pc_issue.

## Timing
- Reset (async assert, takes effect immediately):
  - pc_issue=RESET_PC, so mem_addr=RESET_PC
  - inflight_valid=0, count=0, pointers=0, FIFO storage=0
  - out_valid=0, out_instr=0, out_pc=0
- Reset mid-operation discards all in-flight and buffered words. No partial beat is presented after reset.
- Latency: an address issued at edge E is pushed at E+1; with an empty FIFO, out_valid is high after E+1. That is 2 edges from issue to out_valid.
- After reset release, with fetch_en=1 and out_ready=1:
  - first beat (out_pc=RESET_PC) presented after the 2nd edge
  - one beat every cycle thereafter
- Redirect at edge R:
  - out_valid=0 for cycles R..R+1
  - beat with out_pc=redirect_pc presented after R+2
  - 2-cycle bubble
- Sustained throughput is 1 instruction/cycle while out_ready=1.
- Back-pressure: with out_ready held low, the FIFO fills to 2 and issue stops. out_instr/out_pc stay stable while out_valid=1 and out_ready=0.
- Simultaneous redirect_valid and rst: rst wins.

## Test plan
- Reset, memory words 0..9 = A00000AA,10000011,…,90000099; fetch_en=1, out_ready=1 -> out_pc 0,4,8,… on consecutive cycles with out_instr A00000AA,10000011,20000022,…; first out_valid 2 edges after reset release.
- Hold out_ready=0 from the 3rd beat for 5 cycles -> count saturates at 2; mem_addr stops advancing at 0x10; out_pc=0x08/out_instr=20000022 stable; on release, beats 0x08,0x0C,0x10,… with no gap or duplicate.
- redirect_valid pulse with redirect_pc=0x1E (low bits forced 0) during streaming -> out_valid low 2 cycles, then out_pc=0x1C, out_instr=70000077, then 0x20/80000088.
- Redirect on a cycle with count=2 and out_ready=0 -> all buffered words dropped; the next beat is the redirect target.
- fetch_en toggled 1-0-1 with random out_ready -> the out_pc sequence is strictly +4 with no loss or repeat; checked by a scoreboard against a memory model.
- Assert rst asynchronously mid-stream (between edges) -> out_valid=0 and mem_addr=RESET_PC immediately; fetch restarts from RESET_PC after release.
